// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between instruction fetch and load/store.
// Accesses are serialized IDLE -> ACCESS -> RESP with round-robin arbitration on contention.
module mem_port_arbiter #(
  parameter int AWL = 6,
  parameter int DWL = 32
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           F_REQ,
  input  logic [AWL-1:0] F_ADDR,
  output logic           F_GNT,
  output logic           F_VALID,
  output logic [DWL-1:0] F_RD,
  input  logic           D_REQ,
  input  logic           D_WE,
  input  logic [AWL-1:0] D_ADDR,
  input  logic [DWL-1:0] D_WD,
  output logic           D_GNT,
  output logic           D_VALID,
  output logic [DWL-1:0] D_RD,
  output logic           MWE,
  output logic [AWL-1:0] MRA,
  output logic [DWL-1:0] MWD,
  input  logic [DWL-1:0] MRD,
  output logic           BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [AWL-1:0] addr_q, addr_d;
  logic [DWL-1:0] wd_q, wd_d;
  logic           we_q, we_d;
  logic [DWL-1:0] f_rd_q, f_rd_d, d_rd_q, d_rd_d;
  logic           f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
  logic           f_vld_q, f_vld_d, d_vld_q, d_vld_d;
  logic           mwe_q, mwe_d, busy_q, busy_d;
  logic [AWL-1:0] mra_q, mra_d;
  logic [DWL-1:0] mwd_q, mwd_d;
  logic           take, pick, acc;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    we_d    = we_q;
    f_rd_d  = f_rd_q;
    d_rd_d  = d_rd_q;
    take    = 1'b0;
    pick    = OWN_F;
    case (state_q)
      S_IDLE: begin
        if (F_REQ || D_REQ) begin
          take = 1'b1;
          pick = (D_REQ && (!F_REQ || last_q == OWN_F)) ? OWN_D : OWN_F;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        last_d  = owner_q;
        if (!we_q) begin
          if (owner_q == OWN_D) d_rd_d = MRD;
          else                  f_rd_d = MRD;
        end
      end
      S_RESP: begin
        // The completing owner's REQ is ignored; only the other side may chain.
        if ((owner_q == OWN_F) ? D_REQ : F_REQ) begin
          take = 1'b1;
          pick = ~owner_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      state_d = S_ACCESS;
      owner_d = pick;
      if (pick == OWN_D) begin
        addr_d = D_ADDR;
        wd_d   = D_WD;
        we_d   = D_WE;
      end else begin
        addr_d = F_ADDR;
        wd_d   = '0;
        we_d   = 1'b0;
      end
    end
    // Outputs are decoded from next state so they come straight off flops.
    acc     = (state_d == S_ACCESS);
    f_gnt_d = acc && (owner_d == OWN_F);
    d_gnt_d = acc && (owner_d == OWN_D);
    mwe_d   = acc && we_d;
    mra_d   = acc ? addr_d : '0;
    mwd_d   = acc ? wd_d : '0;
    f_vld_d = (state_d == S_RESP) && (owner_d == OWN_F);
    d_vld_d = (state_d == S_RESP) && (owner_d == OWN_D);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      owner_q <= OWN_F;
      last_q  <= OWN_D;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      f_rd_q  <= '0;
      d_rd_q  <= '0;
      f_gnt_q <= 1'b0;
      d_gnt_q <= 1'b0;
      f_vld_q <= 1'b0;
      d_vld_q <= 1'b0;
      mwe_q   <= 1'b0;
      mra_q   <= '0;
      mwd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      f_rd_q  <= f_rd_d;
      d_rd_q  <= d_rd_d;
      f_gnt_q <= f_gnt_d;
      d_gnt_q <= d_gnt_d;
      f_vld_q <= f_vld_d;
      d_vld_q <= d_vld_d;
      mwe_q   <= mwe_d;
      mra_q   <= mra_d;
      mwd_q   <= mwd_d;
      busy_q  <= busy_d;
    end
  end

  assign F_GNT   = f_gnt_q;
  assign D_GNT   = d_gnt_q;
  assign F_VALID = f_vld_q;
  assign D_VALID = d_vld_q;
  assign F_RD    = f_rd_q;
  assign D_RD    = d_rd_q;
  assign MWE     = mwe_q;
  assign MRA     = mra_q;
  assign MWD     = mwd_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
module tb_mem_port_arbiter;
  localparam int AWL = 6;
  localparam int DWL = 32;

  logic           CLK = 1'b0;
  logic           RSTN = 1'b0;
  logic           F_REQ = 1'b0, D_REQ = 1'b0, D_WE = 1'b0;
  logic [AWL-1:0] F_ADDR = '0, D_ADDR = '0;
  logic [DWL-1:0] D_WD = '0;
  logic           F_GNT, F_VALID, D_GNT, D_VALID, MWE, BUSY;
  logic [DWL-1:0] F_RD, D_RD, MWD, MRD;
  logic [AWL-1:0] MRA;

  logic [DWL-1:0] mem [0:(1<<AWL)-1];
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  assign MRD = mem[MRA];
  always @(posedge CLK) if (MWE) mem[MRA] <= MWD;

  mem_port_arbiter #(.AWL(AWL), .DWL(DWL)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_GNT(F_GNT), .F_VALID(F_VALID), .F_RD(F_RD),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WD(D_WD),
    .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RD(D_RD),
    .MWE(MWE), .MRA(MRA), .MWD(MWD), .MRD(MRD), .BUSY(BUSY)
  );

  task automatic do_reset();
    @(negedge CLK);
    RSTN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    #1;
    checks++;
    if ({F_GNT, D_GNT, F_VALID, D_VALID, MWE, BUSY} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {F_GNT, D_GNT, F_VALID, D_VALID, MWE, BUSY});
    end
    checks++;
    if (MRA !== '0 || MWD !== '0 || F_RD !== '0 || D_RD !== '0) begin
      errors++; $display("FAIL reset_data: MRA=%0h MWD=%0h F_RD=%0h D_RD=%0h want all 0", MRA, MWD, F_RD, D_RD);
    end
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    mem[5] = 32'h55555555;
    @(negedge CLK);
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 6'd5; D_WD = 32'hDEADBEEF;
    @(negedge CLK);
    checks++;
    if (MWE !== 1'b1 || D_GNT !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: MWE=%b D_GNT=%b want 1 1", MWE, D_GNT);
    end
    RSTN = 1'b0;
    #1;
    checks++;
    if ({MWE, BUSY, F_VALID, D_VALID, D_GNT} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: MWE,BUSY,FV,DV,DG=%b want 00000", {MWE, BUSY, F_VALID, D_VALID, D_GNT});
    end
    @(negedge CLK);
    D_REQ = 1'b0; D_WE = 1'b0;
    checks++;
    if (mem[5] !== 32'h55555555 || D_VALID !== 1'b0) begin
      errors++; $display("FAIL rst_mid_mem: RAM[5]=%h D_VALID=%b want 55555555 0", mem[5], D_VALID);
    end
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_single_fetch();
    mem[3] = 32'h12345678;
    @(negedge CLK);
    F_REQ = 1'b1; F_ADDR = 6'd3;
    @(negedge CLK);
    checks++;
    if (F_GNT !== 1'b1 || MRA !== 6'd3 || MWE !== 1'b0 || D_GNT !== 1'b0) begin
      errors++; $display("FAIL fetch_access: F_GNT=%b MRA=%0d MWE=%b D_GNT=%b want 1 3 0 0", F_GNT, MRA, MWE, D_GNT);
    end
    @(negedge CLK);
    checks++;
    if (F_VALID !== 1'b1 || F_RD !== 32'h12345678 || F_GNT !== 1'b0 || MRA !== '0) begin
      errors++; $display("FAIL fetch_resp: F_VALID=%b F_RD=%h F_GNT=%b MRA=%0d want 1 12345678 0 0", F_VALID, F_RD, F_GNT, MRA);
    end
    F_REQ = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || F_VALID !== 1'b0 || F_RD !== 32'h12345678) begin
      errors++; $display("FAIL fetch_done: BUSY=%b F_VALID=%b F_RD=%h want 0 0 12345678", BUSY, F_VALID, F_RD);
    end
  endtask

  task automatic test_store_load();
    mem[10] = 32'h0;
    @(negedge CLK);
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 6'd10; D_WD = 32'hA5A5A5A5;
    @(negedge CLK);
    checks++;
    if (MWE !== 1'b1 || D_GNT !== 1'b1 || MRA !== 6'd10 || MWD !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL store_access: MWE=%b D_GNT=%b MRA=%0d MWD=%h want 1 1 10 a5a5a5a5", MWE, D_GNT, MRA, MWD);
    end
    @(negedge CLK);
    checks++;
    if (MWE !== 1'b0 || D_VALID !== 1'b1 || D_RD !== 32'h0 || mem[10] !== 32'hA5A5A5A5 || MWD !== '0) begin
      errors++; $display("FAIL store_resp: MWE=%b D_VALID=%b D_RD=%h RAM[10]=%h MWD=%h want 0 1 0 a5a5a5a5 0",
                         MWE, D_VALID, D_RD, mem[10], MWD);
    end
    D_REQ = 1'b0; D_WE = 1'b0;
    @(negedge CLK);
    checks++;
    if (D_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL store_done: D_VALID=%b BUSY=%b want 0 0", D_VALID, BUSY);
    end
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 6'd10; D_WD = 32'hFFFFFFFF;
    @(negedge CLK);
    checks++;
    if (MWE !== 1'b0 || D_GNT !== 1'b1) begin
      errors++; $display("FAIL load_access: MWE=%b D_GNT=%b want 0 1", MWE, D_GNT);
    end
    @(negedge CLK);
    checks++;
    if (D_VALID !== 1'b1 || D_RD !== 32'hA5A5A5A5 || mem[10] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL load_resp: D_VALID=%b D_RD=%h RAM[10]=%h want 1 a5a5a5a5 a5a5a5a5", D_VALID, D_RD, mem[10]);
    end
    D_REQ = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_contention();
    mem[20] = 32'h11111111;
    mem[21] = 32'h22222222;
    do_reset();
    F_REQ = 1'b1; F_ADDR = 6'd20;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 6'd21;
    @(negedge CLK);
    checks++;
    if (F_GNT !== 1'b1 || D_GNT !== 1'b0 || MRA !== 6'd20) begin
      errors++; $display("FAIL cont_t1: F_GNT=%b D_GNT=%b MRA=%0d want 1 0 20", F_GNT, D_GNT, MRA);
    end
    @(negedge CLK);
    checks++;
    if (F_VALID !== 1'b1 || D_VALID !== 1'b0 || F_RD !== 32'h11111111) begin
      errors++; $display("FAIL cont_t2: F_VALID=%b D_VALID=%b F_RD=%h want 1 0 11111111", F_VALID, D_VALID, F_RD);
    end
    F_REQ = 1'b0;
    @(negedge CLK);
    checks++;
    if (D_GNT !== 1'b1 || F_GNT !== 1'b0 || BUSY !== 1'b1 || MRA !== 6'd21) begin
      errors++; $display("FAIL cont_t3: D_GNT=%b F_GNT=%b BUSY=%b MRA=%0d want 1 0 1 21", D_GNT, F_GNT, BUSY, MRA);
    end
    @(negedge CLK);
    checks++;
    if (D_VALID !== 1'b1 || F_VALID !== 1'b0 || D_RD !== 32'h22222222) begin
      errors++; $display("FAIL cont_t4: D_VALID=%b F_VALID=%b D_RD=%h want 1 0 22222222", D_VALID, F_VALID, D_RD);
    end
    D_REQ = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL cont_t5: BUSY=%b want 0", BUSY);
    end
  endtask

  // Last served is D after the contention test, so fetch leads.
  task automatic test_round_robin();
    logic exp_d;
    int   grants;
    exp_d  = 1'b0;
    grants = 0;
    @(negedge CLK);
    F_REQ = 1'b1; F_ADDR = 6'd1;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 6'd2;
    for (int c = 0; c < 40 && grants < 8; c++) begin
      @(negedge CLK);
      if (F_GNT && D_GNT) begin
        checks++; errors++;
        $display("FAIL rr_both: both grants high at cycle %0d", c);
      end else if (F_GNT || D_GNT) begin
        checks++;
        if (D_GNT !== exp_d) begin
          errors++; $display("FAIL rr_order: grant %0d went to %s want %s", grants, D_GNT ? "D" : "F", exp_d ? "D" : "F");
        end
        exp_d = ~exp_d;
        grants++;
      end
    end
    checks++;
    if (grants != 8) begin
      errors++; $display("FAIL rr_count: grants=%0d want 8 within 40 cycles", grants);
    end
    F_REQ = 1'b0; D_REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_idle();
    logic [DWL-1:0] snap [0:(1<<AWL)-1];
    int bad;
    int diff;
    bad  = 0;
    diff = 0;
    for (int i = 0; i < (1<<AWL); i++) snap[i] = mem[i];
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (MWE !== 1'b0 || MRA !== '0 || MWD !== '0 || BUSY !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_bus: %0d cycles with active bus, want 0", bad);
    end
    for (int i = 0; i < (1<<AWL); i++) if (mem[i] !== snap[i]) diff++;
    checks++;
    if (diff != 0) begin
      errors++; $display("FAIL idle_mem: %0d words changed, want 0", diff);
    end
  endtask

  initial begin
    for (int i = 0; i < (1<<AWL); i++) mem[i] = 32'h0;
    test_reset();
    test_reset_mid_access();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_round_robin();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller that shares the single-port unified Memory (combinational read, write on posedge CLK) between the instruction-fetch requester and the load/store data requester of the multi-cycle core. It owns the Memory MWE/MRA/MWD inputs and captures MRD into per-requester response registers. Accesses are serialized by a three-state FSM with round-robin arbitration on contention. Each access returns a one-cycle VALID pulse two cycles after it is accepted.

## Interface
- AWL, 6, address width; matches Memory AWL
- DWL, 32, data width; matches Memory DWL
- CLK  in  1  system clock; all state updates on rising edge
- RSTN  in  1  asynchronous, active-low reset
- F_REQ  in  1  fetch request; held until F_VALID
- F_ADDR  in  AWL  fetch word address; stable while F_REQ=1
- F_GNT  out  1  high during the ACCESS cycle owned by fetch
- F_VALID  out  1  one-cycle pulse; F_RD valid
- F_RD  out  DWL  fetched word; held until the next fetch response
- D_REQ  in  1  data request; held until D_VALID
- D_WE  in  1  1=store, 0=load; stable while D_REQ=1
- D_ADDR  in  AWL  data word address
- D_WD  in  DWL  store data
- D_GNT  out  1  high during the ACCESS cycle owned by data
- D_VALID  out  1  one-cycle pulse; load data valid or store committed
- D_RD  out  DWL  loaded word; unchanged by stores
- MWE  out  1  to Memory MWE
- MRA  out  AWL  to Memory MRA
- MWD  out  DWL  to Memory MWD
- MRD  in  DWL  from Memory MRD
- BUSY  out  1  1 whenever state is not IDLE

## Operation
- States: IDLE, ACCESS, RESP. Registers: state, OWNER (F/D), LAST (last served), latched ADDR/WD/WE, F_RD, D_RD.
- IDLE: if any REQ=1, select the winner, latch its ADDR (plus WD and WE for data; WE is forced to 0 for fetch), set OWNER, and go to ACCESS. Otherwise stay in IDLE.
- Arbitration: a single requester wins. If both request, the winner is the requester not equal to LAST. LAST updates to OWNER on entry to RESP.
- ACCESS:
  - MRA = latched ADDR.
  - MWE = latched WE.
  - MWD = latched WD.
  - Owner's GNT = 1.
  - At the closing edge, MRD is captured into the owner's RD register, but only if WE=0. A store commits to Memory on the same edge.
  - Next state is always RESP.
- RESP:
  - Owner's VALID = 1.
  - The owner's REQ is ignored this cycle, because it is completing.
  - If the other requester's REQ=1, latch it and go directly to ACCESS (back-to-back). Otherwise go to IDLE.
- Outside ACCESS: MWE=0, MRA=0, MWD=0, and both GNT outputs are 0. Memory is never written outside ACCESS.
- A requester deasserting REQ before VALID is a protocol violation. The latched access still completes and VALID still pulses.
- All outputs are driven from registered state only. There is no combinational path from any REQ input to MWE, GNT or VALID.

## Timing
- Reset (RSTN=0, takes effect immediately without a clock):
  - state=IDLE, LAST=D, so fetch wins the first tie.
  - F_RD=0, D_RD=0.
  - All GNT, VALID, MWE, BUSY = 0; MRA=0, MWD=0.
- Reset asserted during ACCESS: MWE falls at once, so the pending store is not committed and no VALID pulse occurs. The first access after reset release restarts from IDLE.
- Latency:
  - REQ seen in IDLE at cycle t.
  - ACCESS at t+1.
  - VALID and RD valid at t+2.
- Sustained throughput under contention is one access per 2 cycles (ACCESS/RESP alternation). A single requester re-requesting alone also gets one access per 3 cycles (RESP→IDLE→ACCESS), because its own REQ is ignored in RESP.
- Simultaneous F_REQ and D_REQ with LAST=D: fetch at t+1, data ACCESS at t+3, D_VALID at t+4.

## Test plan
- **Reset:** drive RSTN=0 mid-ACCESS of a store D_ADDR=5, D_WD=32'hDEADBEEF. Required: MWE=0 immediately, RAM[5] unchanged, all VALID=0, BUSY=0.
- **Single fetch:** F_REQ with F_ADDR=3, RAM[3]=32'h12345678. Required: F_GNT and MRA=3 at t+1, F_VALID=1 and F_RD=32'h12345678 at t+2, BUSY=0 at t+3.
- **Store then load:**
  - D_WE=1, D_ADDR=10, D_WD=32'hA5A5A5A5. Required: MWE=1 only at t+1, D_VALID at t+2, D_RD unchanged.
  - Follow with a load from address 10. Required: D_RD=32'hA5A5A5A5.
- **Contention after reset:** F_REQ and D_REQ both rise at t. Required:
  - F_GNT at t+1, F_VALID at t+2.
  - D_GNT at t+3, D_VALID at t+4.
  - No IDLE cycle between the two accesses.
- **Round-robin fairness:** both REQ held continuously for 8 accesses. Required: grants alternate F,D,F,D,… and neither port is ever granted twice in a row while the other waits.
- **Idle bus:** no requests for 10 cycles. Required: MWE=0, MRA=0, MWD=0, BUSY=0 every cycle, and Memory contents unchanged.
